// File: rtl/dff.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : dff
// Brief   : Positive-edge D flip-flop (WIDTH bits) with async active-low reset.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module dff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] D,
  input  logic             Clock,
  input  logic             reset,
  output logic [WIDTH-1:0] Q
);

  // Q is a pure register: no combinational path from D, and reset wins over Clock.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      Q <= RESET_VALUE;
    end else begin
      Q <= D;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dff.sv
`default_nettype none
// Scoreboard bench for dff: single cell, 8-bit parallel register,
// 8-stage shift chain and a WIDTH=4 / RESET_VALUE=4'hC variant.
module tb_dff;

  logic       Clock;
  logic       rst_a, rst_p, rst_s, rst_c;
  logic       d1, q1;
  logic [7:0] inp, res_par;
  logic       sin;
  logic [7:0] res_chain;
  logic [3:0] d4, q4;

  dff u_single (.D(d1), .Clock(Clock), .reset(rst_a), .Q(q1));

  dff #(.WIDTH(8)) u_par (.D(inp), .Clock(Clock), .reset(rst_p), .Q(res_par));

  dff #(.WIDTH(4), .RESET_VALUE(4'hC)) u_param (.D(d4), .Clock(Clock), .reset(rst_c), .Q(q4));

  for (genvar i = 0; i < 8; i++) begin : g_chain
    if (i == 0) begin : g_head
      dff u_stage (.D(sin), .Clock(Clock), .reset(rst_s), .Q(res_chain[0]));
    end else begin : g_body
      dff u_stage (.D(res_chain[i-1]), .Clock(Clock), .reset(rst_s), .Q(res_chain[i]));
    end
  end

  initial Clock = 1'b0;
  always #50 Clock = ~Clock;

  typedef struct {
    int         sel;
    logic [7:0] exp;
    string      name;
  } sb_item_t;

  sb_item_t sb[$];
  event     sample;
  int       n_total = 0;
  int       n_pass  = 0;

  function automatic logic [7:0] dut_out(input int sel);
    case (sel)
      0:       return {7'b0, q1};
      1:       return res_chain;
      2:       return {7'b0, res_chain[7]};
      3:       return res_par;
      default: return {4'b0, q4};
    endcase
  endfunction

  // Monitor: drains the scoreboard each time the stimulus declares outputs valid.
  initial begin
    forever begin
      @(sample);
      while (sb.size() > 0) begin
        sb_item_t it;
        logic [7:0] got;
        it  = sb.pop_front();
        got = dut_out(it.sel);
        n_total++;
        if (got === it.exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", it.name, got, it.exp, $time);
      end
    end
  end

  task automatic expect_out(input int sel, input logic [7:0] exp, input string name);
    sb_item_t it;
    it.sel  = sel;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
    #1;
    ->sample;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic       cap_vals [3]  = '{1'b0, 1'b1, 1'b0};
  logic       sin_vals [9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] chain_exp [9] = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h15, 8'h2A, 8'h54, 8'hA8, 8'h50};

  initial begin
    rst_a = 1'b1; rst_p = 1'b1; rst_s = 1'b1; rst_c = 1'b1;
    d1 = 1'b0; inp = 8'h00; sin = 1'b0; d4 = 4'h0;
    #1;
    rst_a = 1'b0; rst_p = 1'b0; rst_s = 1'b0; rst_c = 1'b0;
    d1 = 1'b1; inp = 8'hFF; sin = 1'b1; d4 = 4'hF;
    #4;
    // All resets asserted before any Clock edge: values must already be loaded.
    expect_out(0, 8'h00, "rst_async_single");
    expect_out(1, 8'h00, "rst_async_chain");
    expect_out(3, 8'h00, "rst_async_par");
    expect_out(4, 8'h0C, "rst_async_param");

    @(posedge Clock); expect_out(0, 8'h00, "rst_hold_e1");
    @(posedge Clock); expect_out(0, 8'h00, "rst_hold_e2");

    // Release coincident with the edge; NBA keeps the DUT seeing reset low there.
    @(posedge Clock);
    rst_a <= 1'b1;
    expect_out(0, 8'h00, "release_edge_no_capture");
    @(posedge Clock); expect_out(0, 8'h01, "release_next_edge");

    foreach (cap_vals[i]) begin
      @(negedge Clock); d1 = cap_vals[i];
      @(posedge Clock); expect_out(0, {7'b0, cap_vals[i]}, "capture");
    end

    @(negedge Clock); d1 = 1'b1;
    #1 expect_out(0, 8'h00, "stable_between_edges");
    @(posedge Clock); expect_out(0, 8'h01, "capture_after_stable");
    @(posedge Clock); expect_out(0, 8'h01, "no_enable_reload");

    #20 rst_a = 1'b0;
    expect_out(0, 8'h00, "async_mid_high");
    @(posedge Clock); expect_out(0, 8'h00, "reset_ignores_clock");

    @(negedge Clock); rst_c = 1'b1; d4 = 4'h3;
    #1 expect_out(4, 8'h0C, "param_pre_edge");
    @(posedge Clock); expect_out(4, 8'h03, "param_capture");

    @(negedge Clock); rst_p = 1'b1; inp = 8'hA5;
    @(posedge Clock); expect_out(3, 8'hA5, "par_a5");
    @(negedge Clock); inp = 8'h3C;
    @(posedge Clock); expect_out(3, 8'h3C, "par_3c");
    #20 rst_p = 1'b0;
    expect_out(3, 8'h00, "par_async_reset");

    foreach (sin_vals[i]) begin
      @(negedge Clock);
      if (i == 0) rst_s = 1'b1;
      sin = sin_vals[i];
      @(posedge Clock);
      expect_out(1, chain_exp[i], "chain_res");
      if (i == 6) expect_out(2, 8'h00, "chain_sout_e7");
      if (i == 7) expect_out(2, 8'h01, "chain_sout_e8");
    end
    #20 rst_s = 1'b0;
    expect_out(1, 8'h00, "chain_async_reset");

    #10;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
